// File: rtl/key_event_gen.sv
// Turns the debounced key level into PRESS / RELEASE / LONG / REPEAT events held in a
// single-entry valid/ready output register. Define KEY_AUTOREPEAT_EN to enable REPEAT events.
module key_event_gen #(
   parameter int unsigned LONG_CYC   = 50_000_000,
   parameter int unsigned REPEAT_CYC = 10_000_000,
   parameter int unsigned CNT_W      = 26
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       db_level_i,
   input  logic       event_ready_i,
   input  logic       ovf_clr_i,
   output logic       event_valid_o,
   output logic [1:0] event_code_o,
   output logic       overflow_o,
   output logic [1:0] state_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HELD = 2'd1,
      ST_LONG = 2'd2
   } state_t;

   localparam logic [1:0] EV_PRESS   = 2'd0;
   localparam logic [1:0] EV_RELEASE = 2'd1;
   localparam logic [1:0] EV_LONG    = 2'd2;
   localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYC - 32'd1);
`ifdef KEY_AUTOREPEAT_EN
   localparam logic [1:0] EV_REPEAT  = 2'd3;
   localparam logic [CNT_W-1:0] REP_TC = CNT_W'(REPEAT_CYC - 32'd1);
`endif

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic             ev_gen_s;
   logic [1:0]       ev_code_s;
   logic             drop_s;

   // Event decode: release wins over any terminal count reached in the same cycle.
   always_comb begin
      ev_gen_s  = 1'b0;
      ev_code_s = EV_PRESS;
      case (state_r)
         ST_IDLE: begin
            if (db_level_i) begin
               ev_gen_s  = 1'b1;
               ev_code_s = EV_PRESS;
            end else begin
               ev_gen_s  = 1'b0;
            end
         end
         ST_HELD: begin
            if (!db_level_i) begin
               ev_gen_s  = 1'b1;
               ev_code_s = EV_RELEASE;
            end else if (cnt_r == LONG_TC) begin
               ev_gen_s  = 1'b1;
               ev_code_s = EV_LONG;
            end else begin
               ev_gen_s  = 1'b0;
            end
         end
         ST_LONG: begin
            if (!db_level_i) begin
               ev_gen_s  = 1'b1;
               ev_code_s = EV_RELEASE;
`ifdef KEY_AUTOREPEAT_EN
            end else if (cnt_r == REP_TC) begin
               ev_gen_s  = 1'b1;
               ev_code_s = EV_REPEAT;
`endif
            end else begin
               ev_gen_s  = 1'b0;
            end
         end
         default: begin
            ev_gen_s  = 1'b0;
            ev_code_s = EV_PRESS;
         end
      endcase
      drop_s = ev_gen_s & event_valid_o & ~event_ready_i;
   end

   // State, hold counter and the single-entry event register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_r       <= ST_IDLE;
         cnt_r         <= '0;
         event_valid_o <= 1'b0;
         event_code_o  <= 2'd0;
         overflow_o    <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               cnt_r <= '0;
               if (db_level_i) begin
                  state_r <= ST_HELD;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_HELD: begin
               if (!db_level_i) begin
                  state_r <= ST_IDLE;
                  cnt_r   <= '0;
               end else if (cnt_r == LONG_TC) begin
                  state_r <= ST_LONG;
                  cnt_r   <= '0;
               end else begin
                  cnt_r   <= cnt_r + 1'b1;
               end
            end
            ST_LONG: begin
               if (!db_level_i) begin
                  state_r <= ST_IDLE;
                  cnt_r   <= '0;
`ifdef KEY_AUTOREPEAT_EN
               end else if (cnt_r == REP_TC) begin
                  cnt_r   <= '0;
               end else begin
                  cnt_r   <= cnt_r + 1'b1;
               end
`else
               end else begin
                  cnt_r   <= '0;
               end
`endif
            end
            default: begin
               state_r <= ST_IDLE;
               cnt_r   <= '0;
            end
         endcase

         // A new event replaces the pending one only if the slot is free or being drained.
         if (ev_gen_s && (!event_valid_o || event_ready_i)) begin
            event_valid_o <= 1'b1;
            event_code_o  <= ev_code_s;
         end else if (!ev_gen_s && event_ready_i) begin
            event_valid_o <= 1'b0;
         end else begin
            event_valid_o <= event_valid_o;
         end

         if (drop_s) begin
            overflow_o <= 1'b1;
         end else if (ovf_clr_i) begin
            overflow_o <= 1'b0;
         end else begin
            overflow_o <= overflow_o;
         end
      end
   end

   assign state_o = state_r;

endmodule

// File: tb/tb_key_event_gen.sv
// Self-checking bench for key_event_gen: constant vector table, directed corner sequences and
// randomized traffic compared against a hold-time based reference model.
module tb_key_event_gen;

   localparam int L = 8;
   localparam int R = 4;

   logic       clk = 1'b0;
   logic       rst_i;
   logic       db_level;
   logic       event_ready;
   logic       ovf_clr;
   logic       event_valid;
   logic [1:0] event_code;
   logic       overflow;
   logic [1:0] state;

   int n_vec = 0;
   int n_err = 0;

   // reference model: key up/down plus number of held edges since the press
   bit         m_down;
   int         m_h;
   bit         m_valid;
   logic [1:0] m_code;
   bit         m_ovf;

   typedef struct {
      logic       db;
      logic       rdy;
      logic       clr;
      logic       exp_valid;
      logic [1:0] exp_code;
      logic       exp_ovf;
      logic [1:0] exp_state;
   } vec_t;

   vec_t tbl [14];

   key_event_gen #(.LONG_CYC(L), .REPEAT_CYC(R), .CNT_W(4)) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .db_level_i    (db_level),
      .event_ready_i (event_ready),
      .ovf_clr_i     (ovf_clr),
      .event_valid_o (event_valid),
      .event_code_o  (event_code),
      .overflow_o    (overflow),
      .state_o       (state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_down  = 1'b0;
      m_h     = 0;
      m_valid = 1'b0;
      m_code  = 2'd0;
      m_ovf   = 1'b0;
   endtask

   function automatic int model_state();
      if (!m_down) return 0;
      else if (m_h < L) return 1;
      else return 2;
   endfunction

   task automatic model_edge(input logic db, input logic rdy, input logic clr);
      bit         ev;
      logic [1:0] code;
      ev   = 1'b0;
      code = 2'd0;
      if (!m_down) begin
         if (db) begin ev = 1'b1; code = 2'd0; m_down = 1'b1; m_h = 0; end
      end else if (!db) begin
         ev = 1'b1; code = 2'd1; m_down = 1'b0;
      end else begin
         m_h++;
         if (m_h == L) begin ev = 1'b1; code = 2'd2; end
`ifdef KEY_AUTOREPEAT_EN
         else if (m_h > L && ((m_h - L) % R) == 0) begin ev = 1'b1; code = 2'd3; end
`endif
      end
      if (ev && m_valid && !rdy) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (ev && (!m_valid || rdy)) begin m_valid = 1'b1; m_code = code; end
      else if (!ev && rdy) m_valid = 1'b0;
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_valid"}, 32'(event_valid), 32'(m_valid));
      if (m_valid) chk({tag, "_code"}, 32'(event_code), 32'(m_code));
      chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
      chk({tag, "_state"}, 32'(state), 32'(model_state()));
   endtask

   task automatic step(input logic db, input logic rdy, input logic clr, input string tag);
      db_level    = db;
      event_ready = rdy;
      ovf_clr     = clr;
      @(posedge clk);
      model_edge(db, rdy, clr);
      #1;
      check_model(tag);
   endtask

   initial begin
      int run;
      logic db_r;

      rst_i = 1'b0; db_level = 1'b0; event_ready = 1'b1; ovf_clr = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 32'(event_valid), 32'd0);
      chk("rst_code", 32'(event_code), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_state", 32'(state), 32'd0);
      #2 rst_i = 1'b1;

      // short press, backpressure with drop, overflow clear, clear-vs-drop
      tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 2'd1};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd1};
      tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd1};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd1};
      tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd1};
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd1};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 2'd0};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0};
      tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd1};
      tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 2'd0};
      tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0};

      for (int i = 0; i < 14; i++) begin
         db_level = tbl[i].db; event_ready = tbl[i].rdy; ovf_clr = tbl[i].clr;
         @(posedge clk);
         model_edge(tbl[i].db, tbl[i].rdy, tbl[i].clr);
         #1;
         chk($sformatf("tbl%0d_valid", i), 32'(event_valid), 32'(tbl[i].exp_valid));
         if (tbl[i].exp_valid) chk($sformatf("tbl%0d_code", i), 32'(event_code), 32'(tbl[i].exp_code));
         chk($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(tbl[i].exp_ovf));
         chk($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].exp_state));
      end

      // long hold: PRESS at k=0, LONG at k=8, REPEATs at 12/16/20 when enabled
      for (int k = 0; k <= 20; k++) begin
         step(1'b1, 1'b1, 1'b0, "hold");
         if (k == L) chk("hold_long_code", 32'(event_code), 32'd2);
         if (k >= L) chk("hold_state_long", 32'(state), 32'd2);
`ifdef KEY_AUTOREPEAT_EN
         if (k == 20) chk("hold_rep20", 32'({event_valid, event_code}), 32'({1'b1, 2'd3}));
`else
         if (k > L) chk("hold_norep", 32'(event_valid), 32'd0);
`endif
      end
      step(1'b0, 1'b1, 1'b0, "hold_rel");
      chk("hold_rel_code", 32'(event_code), 32'd1);
      step(1'b0, 1'b1, 1'b0, "idle");

      // release lands on the edge where the counter sits at LONG_CYC-1
      for (int k = 0; k < L; k++) step(1'b1, 1'b1, 1'b0, "rvl_hold");
      step(1'b0, 1'b1, 1'b0, "rvl_drop");
      chk("rvl_code", 32'(event_code), 32'd1);
      chk("rvl_state", 32'(state), 32'd0);
      step(1'b0, 1'b1, 1'b0, "rvl_after");

      // reset while in ST_LONG with a pending event and overflow set
      for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b0, "pre_rst");
      @(negedge clk);
      rst_i = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(event_valid), 32'd0);
      chk("mid_rst_code", 32'(event_code), 32'd0);
      chk("mid_rst_ovf", 32'(overflow), 32'd0);
      chk("mid_rst_state", 32'(state), 32'd0);
      model_reset();
      @(negedge clk);
      rst_i = 1'b1;
      step(1'b1, 1'b1, 1'b0, "post_rst");
      chk("post_rst_press", 32'({event_valid, event_code}), 32'({1'b1, 2'd0}));

      // randomized traffic: random hold/idle run lengths, ready and clear
      db_r = 1'b1;
      run  = 0;
      for (int n = 0; n < 3000; n++) begin
         if (run == 0) begin
            db_r = ~db_r;
            run  = $urandom_range(1, 30);
         end
         run--;
         step(db_r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), "rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/key_event_gen.md
# key_event_gen

Converts the debounced key level into discrete key events: press, release, long-press and auto-repeat. It sits directly downstream of the debounce stage, which drives `db_level_i` high while the key is stably pressed. Each event is held in a single-entry output register with a valid/ready handshake for the consuming control logic.

## Interface
- `LONG_CYC`, 50_000_000 — number of held cycles after PRESS before the LONG event fires; must be ≥ 2.
- `REPEAT_CYC`, 10_000_000 — number of cycles between REPEAT events while long-held; must be ≥ 2.
- `CNT_W`, 26 — width of the hold counter; must hold `max(LONG_CYC, REPEAT_CYC) - 1`.
- `clk_i` input 1 — clock; all logic on the rising edge.
- `rst_i` input 1 — reset, asynchronous, active-low.
- `db_level_i` input 1 — debounced key level, 1 = pressed; synchronous to `clk_i`.
- `event_ready_i` input 1 — the consumer accepts the event when `event_valid_o && event_ready_i`.
- `ovf_clr_i` input 1 — synchronous clear of `overflow_o`.
- `event_valid_o` output 1 — an event is pending in the output register.
- `event_code_o` output 2 — 0 = PRESS, 1 = RELEASE, 2 = LONG, 3 = REPEAT; valid only when `event_valid_o` = 1.
- `overflow_o` output 1 — sticky flag; set when an event is dropped.
- `state_o` output 2 — FSM state for debug: 0 = ST_IDLE, 1 = ST_HELD, 2 = ST_LONG.

## Operation
- **Reset values:** state ST_IDLE, counter 0, `event_valid_o` = 0, `event_code_o` = 0, `overflow_o` = 0, `state_o` = 0.
- **ST_IDLE:**
  - `db_level_i` = 1: generate PRESS, clear the counter, go to ST_HELD.
  - Otherwise: stay.
- **ST_HELD:**
  - `db_level_i` = 0: generate RELEASE, go to ST_IDLE.
  - Counter == `LONG_CYC - 1`: generate LONG, clear the counter, go to ST_LONG.
  - Otherwise: increment the counter.
- **ST_LONG:**
  - `db_level_i` = 0: generate RELEASE, go to ST_IDLE.
  - Otherwise, repeat behaviour is set by Configuration.
- **Release priority:** release has priority over LONG and REPEAT in the same cycle; a terminal count is ignored when the level is low.
- **Counter width:** the counter never wraps, because it is cleared at the terminal count and on each state entry.
- **Event generation:** at most one event is generated per cycle.
- **Output register, applied on the clock edge:**
  - Event generated and (`event_valid_o` = 0 or `event_ready_i` = 1): load the event and hold `event_valid_o` = 1.
  - Event generated while `event_valid_o` = 1 and `event_ready_i` = 0: drop the new event, keep the pending one unchanged, set `overflow_o`.
  - No event and `event_ready_i` = 1: clear `event_valid_o`.
- **Overflow clear:** `ovf_clr_i` clears `overflow_o`. If `ovf_clr_i` and a new drop occur in the same cycle, the set wins and `overflow_o` stays 1.
- **Reset mid-operation:** any pending event is discarded and the FSM returns to ST_IDLE. If `db_level_i` is still high after reset, a fresh PRESS is generated on the first edge after reset.

## Timing
- PRESS and RELEASE: `event_valid_o` rises after the same edge that first samples the new `db_level_i` value (1-cycle latency).
- LONG: appears exactly `LONG_CYC` cycles after the edge that loaded PRESS.
- REPEAT: the first REPEAT appears `REPEAT_CYC` cycles after LONG; later REPEATs follow every `REPEAT_CYC` cycles.
- Handshake: the consumer may hold `event_ready_i` = 1 continuously, giving back-to-back acceptance with no bubble.
- Stability: `event_code_o` is stable while `event_valid_o` = 1 and `event_ready_i` = 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `KEY_AUTOREPEAT_EN`.
- Defined, in ST_LONG with the level still high:
  - Counter == `REPEAT_CYC - 1`: generate REPEAT and clear the counter.
  - Otherwise: increment the counter.
- Undefined: ST_LONG holds the counter at 0 and never generates REPEAT. Code 3 never appears, and `REPEAT_CYC` is unused.

## Test plan
All scenarios use `LONG_CYC` = 8, `REPEAT_CYC` = 4, `CNT_W` = 4.
- **Short press:** `event_ready_i` = 1; raise `db_level_i` for 3 cycles, then drop it → PRESS (code 0) for one cycle after the rising sample, then RELEASE (code 1) one cycle after the falling sample; no LONG.
- **Long hold, `KEY_AUTOREPEAT_EN` defined:** hold `db_level_i` high for 20 cycles → PRESS at t, LONG at t+8, REPEAT at t+12, t+16 and t+20, then RELEASE on drop.
- **Long hold, macro undefined:** same stimulus → PRESS, LONG at t+8, then only RELEASE; `state_o` = 2 throughout the hold.
- **Backpressure:** `event_ready_i` = 0; press for 3 cycles, then release → PRESS stays pending, RELEASE is dropped, `overflow_o` = 1; pulse `ovf_clr_i` → `overflow_o` = 0.
- **Release vs LONG:** drop `db_level_i` exactly on the cycle the counter reaches 7 → RELEASE generated, no LONG, `state_o` returns to 0.
- **Reset mid-hold:** assert `rst_i` = 0 in ST_LONG while `db_level_i` = 1 → all outputs 0 immediately; release reset → PRESS on the first edge.
